// File: rtl/i2c_txn_seq.sv
// Host-side I2C transaction sequencer: command capture, TX byte FIFO, and control of the bit-level i2c_fsm.
// Optional watchdog compiled in with `define I2C_SEQ_TIMEOUT_EN.
module i2c_txn_seq #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned LEN_W          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic             scl_clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [6:0]       cmd_addr,
  input  logic             cmd_rw,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_rep_start,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             done,
  output logic [1:0]       status,
  output logic             seq_busy,
  output logic [6:0]       cfg_address,
  output logic             start,
  output logic             restart,
  output logic             stop,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic             fsm_busy,
  input  logic             fsm_error,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, XFER, CLOSE, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             rw_q, rep_q, rflag_q, abort_q;
  logic [LEN_W-1:0] rem_q;
  logic [1:0]       status_q, code_d;
  logic             done_q, done_d;
  logic             set_rflag, set_abort;
  logic             fifo_empty, fifo_full, push, pop, tx_hs, drain_pop, tmo;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign wr_ready   = !fifo_full;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign push       = wr_valid && (!fifo_full || pop);

  assign tx_valid   = (state_q == XFER) && !rw_q && !fifo_empty && (rem_q != '0);
  assign tx_data    = tx_valid ? mem[rptr_q] : '0;
  assign tx_hs      = tx_valid && tx_ready;
  assign rd_valid   = (state_q == XFER) && rw_q && rx_valid && (rem_q != '0);
  assign rd_data    = rd_valid ? rx_data : '0;
  assign drain_pop  = (state_q == DRAIN) && !rw_q && (rem_q != '0) && !fifo_empty;
  assign pop        = tx_hs || drain_pop;

  assign cmd_ready  = (state_q == IDLE);
  assign seq_busy   = (state_q != IDLE);
  assign start      = (state_q == ISSUE) && !rflag_q;
  assign restart    = (state_q == ISSUE) && rflag_q;
  assign done       = done_q;
  assign status     = status_q;

  always_comb begin
    state_d   = state_q;
    stop      = 1'b0;
    done_d    = 1'b0;
    code_d    = status_q;
    set_rflag = 1'b0;
    set_abort = 1'b0;
    case (state_q)
      IDLE:      if (cmd_valid) state_d = ISSUE;
      ISSUE:     state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (fsm_error) begin
          set_abort = 1'b1;
          state_d   = CLOSE;
        end else if (fsm_busy) begin
          state_d = XFER;
        end
      end
      XFER: begin
        if (fsm_error) begin
          set_abort = 1'b1;
          state_d   = CLOSE;
        end else if (rem_q == '0) begin
          state_d = CLOSE;
        end
      end
      CLOSE: begin
        if (rep_q && !abort_q) begin
          set_rflag = 1'b1;
          done_d    = 1'b1;
          code_d    = 2'b00;
          state_d   = IDLE;
        end else begin
          stop = 1'b1;
          if (!fsm_busy) begin
            done_d  = 1'b1;
            code_d  = abort_q ? 2'b01 : 2'b00;
            state_d = (abort_q && !rw_q) ? DRAIN : IDLE;
          end
        end
      end
      DRAIN:     if (!drain_pop) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (tmo) begin
      stop      = 1'b1;
      done_d    = 1'b1;
      code_d    = 2'b10;
      set_rflag = 1'b0;
      state_d   = DRAIN;
    end
  end

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q;
  logic          tmo_run;

  assign tmo_run = state_q inside {WAIT_BUSY, XFER, CLOSE};
  assign tmo     = tmo_run && (tmo_cnt_q == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge scl_clk) begin
    if (!rst_n || !tmo_run || (state_d != state_q) || tx_hs || rx_valid)
      tmo_cnt_q <= '0;
    else
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end
`else
  // Watchdog compiled out; the parameter is kept so both builds share one interface.
  assign tmo = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

  always_ff @(posedge scl_clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      rem_q       <= '0;
      rw_q        <= 1'b0;
      rep_q       <= 1'b0;
      rflag_q     <= 1'b0;
      abort_q     <= 1'b0;
      cfg_address <= '0;
      done_q      <= 1'b0;
      status_q    <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      status_q <= code_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
      if ((state_q == IDLE) && cmd_valid) begin
        cfg_address <= cmd_addr;
        rw_q        <= cmd_rw;
        rep_q       <= cmd_rep_start;
        rem_q       <= cmd_len;
        abort_q     <= 1'b0;
      end else if (tx_hs || rd_valid || drain_pop) begin
        rem_q <= rem_q - 1'b1;
      end
      if (set_abort) abort_q <= 1'b1;
      if ((state_q == ISSUE) || tmo) rflag_q <= 1'b0;
      else if (set_rflag)           rflag_q <= 1'b1;
    end
  end

  always_ff @(posedge scl_clk) begin
    if (push) mem[wptr_q] <= wr_data;
  end
endmodule

// File: tb/tb_i2c_txn_seq.sv
// Scoreboard bench for i2c_txn_seq: a driver plays host and bit-level FSM, a negedge monitor checks outputs.
`timescale 1ns/1ps
module tb_i2c_txn_seq;
  localparam int unsigned LEN_W = 4;
`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int unsigned TMO = 15;
`else
  localparam int unsigned TMO = 1023;
`endif

  logic scl_clk = 1'b0;
  logic rst_n;
  logic cmd_valid, cmd_ready, cmd_rw, cmd_rep_start;
  logic [6:0] cmd_addr, cfg_address;
  logic [LEN_W-1:0] cmd_len;
  logic [7:0] wr_data, rd_data, tx_data, rx_data;
  logic wr_valid, wr_ready, rd_valid, done, seq_busy;
  logic [1:0] status;
  logic start, restart, stop, tx_valid, tx_ready, fsm_busy, fsm_error, rx_valid;

  always #5 scl_clk = ~scl_clk;

  i2c_txn_seq #(.FIFO_DEPTH(8), .LEN_W(LEN_W), .TIMEOUT_CYCLES(TMO)) dut (
    .scl_clk(scl_clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_len(cmd_len), .cmd_rep_start(cmd_rep_start),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data),
    .rd_valid(rd_valid), .done(done), .status(status), .seq_busy(seq_busy),
    .cfg_address(cfg_address), .start(start), .restart(restart), .stop(stop),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .fsm_busy(fsm_busy),
    .fsm_error(fsm_error), .rx_data(rx_data), .rx_valid(rx_valid)
  );

  logic [33:0] outv;
  assign outv = {cmd_ready, wr_ready, rd_data, rd_valid, done, status, seq_busy,
                 cfg_address, start, restart, stop, tx_data, tx_valid};
  localparam logic [33:0] RST_VEC = {2'b11, 32'h0};

  typedef struct { int kind; logic [6:0] addr; } issue_t;
  typedef struct { logic [1:0] status; logic stop; } done_t;

  issue_t     exp_issue[$];
  done_t      exp_done[$];
  logic [7:0] exp_tx[$], exp_rd[$];
  logic [7:0] mfifo[$];
  logic [7:0] rd_src[$];
  int   n_tests = 0, n_fail = 0;
  logic rflag_m = 1'b0;
  logic cur_rw = 1'b0;
  logic stop_seen = 1'b0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  always @(negedge scl_clk) begin : monitor
    issue_t ei;
    done_t  ed;
    if (!rst_n) begin
      stop_seen = 1'b0;
    end else begin
      if (start || restart) begin
        if (exp_issue.size() == 0) check("issue_unexpected", {restart, start}, 0);
        else begin
          ei = exp_issue.pop_front();
          check("issue_kind", {restart, start}, ei.kind);
          check("cfg_address", cfg_address, ei.addr);
        end
      end
      if (stop) stop_seen = 1'b1;
      if (cur_rw && tx_valid) check("tx_valid_on_read", tx_valid, 0);
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) check("tx_extra_hs", tx_valid & tx_ready, 0);
        else check("tx_data", tx_data, exp_tx.pop_front());
      end
      if (rd_valid) begin
        check("rd_passthru", rd_data, rx_data);
        if (exp_rd.size() == 0) check("rd_extra", rd_valid, 0);
        else check("rd_data", rd_data, exp_rd.pop_front());
      end
      if (done) begin
        if (exp_done.size() == 0) check("done_unexpected", done, 0);
        else begin
          ed = exp_done.pop_front();
          check("status", status, ed.status);
          check("stop_seen", stop_seen, ed.stop);
          check("tx_left_at_done", exp_tx.size(), 0);
          check("rd_left_at_done", exp_rd.size(), 0);
        end
        stop_seen = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge scl_clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid = 0; cmd_addr = '0; cmd_rw = 0; cmd_len = '0; cmd_rep_start = 0;
    wr_data = '0; wr_valid = 0; tx_ready = 0; fsm_busy = 0; fsm_error = 0;
    rx_data = '0; rx_valid = 0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    int g = 0;
    wr_valid = 1; wr_data = b;
    while (!wr_ready && g < 50) begin tick(); g++; end
    if (g == 50) check("push_timeout", wr_ready, 1);
    tick();
    wr_valid = 0;
    mfifo.push_back(b);
  endtask

  task automatic send_cmd(input logic [6:0] addr, input logic rw, input int len, input logic rep);
    int g = 0;
    issue_t is;
    is.kind = rflag_m ? 2 : 1; is.addr = addr;
    exp_issue.push_back(is);
    cur_rw = rw;
    cmd_addr = addr; cmd_rw = rw; cmd_len = LEN_W'(len); cmd_rep_start = rep; cmd_valid = 1;
    while (!cmd_ready && g < 50) begin tick(); g++; end
    if (g == 50) check("cmd_ready_timeout", cmd_ready, 1);
    tick();
    cmd_valid = 0;
    g = 0;
    while (!(start || restart) && g < 10) begin tick(); g++; end
    if (g == 10) check("issue_timeout", start | restart, 1);
  endtask

  task automatic run_txn(input logic [6:0] addr, input logic rw, input int len, input logic rep,
                         input int nack_after, input logic full_push, input logic [7:0] fp_byte);
    int cnt, g;
    logic nack_m, nacked, hs, fp_done;
    logic [7:0] b;
    done_t d;
    nack_m = (nack_after >= 0);
    if (!rw) begin
      for (int i = 0; i < len; i++) begin
        b = mfifo.pop_front();
        if (!nack_m || i < nack_after) exp_tx.push_back(b);
      end
    end else begin
      while (rd_src.size() < len) rd_src.push_back(8'($urandom));
      for (int i = 0; i < len; i++) exp_rd.push_back(rd_src[i]);
    end
    d.status = nack_m ? 2'b01 : 2'b00;
    d.stop   = !(rep && !nack_m);
    exp_done.push_back(d);
    send_cmd(addr, rw, len, rep);
    rflag_m = rep && !nack_m;
    fsm_busy = 1;
    tick();
    tick();
    cnt = 0; g = 0; nacked = 0; fp_done = 0;
    while (cnt < len && !nacked && g < 300) begin
      if (!rw && nack_m && cnt == nack_after) begin
        tx_ready = 0; fsm_error = 1;
        tick();
        fsm_error = 0; nacked = 1;
      end else if (!rw) begin
        tx_ready = full_push || ($urandom_range(0, 3) != 0);
        hs = tx_valid && tx_ready;
        if (full_push && hs && !fp_done) begin wr_valid = 1; wr_data = fp_byte; end
        tick();
        if (wr_valid) begin
          wr_valid = 0; fp_done = 1;
          mfifo.push_back(fp_byte);
          check("wr_ready_full_swap", wr_ready, 0);
        end
        if (hs) cnt++;
      end else begin
        rx_valid = ($urandom_range(0, 3) != 0);
        rx_data  = rx_valid ? rd_src[0] : 8'($urandom);
        tick();
        if (rx_valid) begin b = rd_src.pop_front(); cnt++; end
        rx_valid = 0;
      end
      g++;
    end
    if (g >= 300) check("xfer_stall", cnt, len);
    tx_ready = 0; rx_valid = 0;
    if (d.stop) begin
      g = 0;
      while (!stop && g < 20) begin tick(); g++; end
      if (g == 20) check("stop_timeout", stop, 1);
      tick();
      tick();
      fsm_busy = 0;
    end
    g = 0;
    while (!done && g < 20) begin tick(); g++; end
    if (g == 20) check("done_timeout", done, 1);
    fsm_busy = 0;
    g = 0;
    while (seq_busy && g < 30) begin tick(); g++; end
    if (g == 30) check("idle_timeout", seq_busy, 0);
    tick();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    tick();
    exp_issue.delete(); exp_done.delete(); exp_tx.delete(); exp_rd.delete();
    mfifo.delete(); rd_src.delete();
    rflag_m = 0;
    tick();
    rst_n = 1;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin : main
    int n, len, nk;
    logic rw, rep, seen;
    idle_inputs();
    rst_n = 0;
    tick();
    tick();
    check("reset_outputs", outv, RST_VEC);
    rst_n = 1;
    tick();

    push_byte(8'hA1); push_byte(8'h5C); push_byte(8'h3E);
    run_txn(7'h50, 0, 3, 0, -1, 0, 8'h00);

    rd_src.push_back(8'h7F); rd_src.push_back(8'h00);
    run_txn(7'h21, 1, 2, 0, -1, 0, 8'h00);

    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    run_txn(7'h33, 0, 4, 0, 1, 0, 8'h00);
    push_byte(8'h96);
    run_txn(7'h34, 0, 1, 0, -1, 0, 8'h00);

    push_byte(8'hC3);
    run_txn(7'h48, 0, 1, 1, -1, 0, 8'h00);
    run_txn(7'h48, 1, 1, 0, -1, 0, 8'h00);

    for (int i = 0; i < 8; i++) push_byte(8'(8'hB0 + i));
    check("wr_ready_full", wr_ready, 0);
    run_txn(7'h10, 0, 1, 0, -1, 1, 8'hEE);
    run_txn(7'h10, 0, 8, 0, -1, 0, 8'h00);

    run_txn(7'h7A, 0, 0, 0, -1, 0, 8'h00);

    repeat (24) begin
      rw  = 1'($urandom_range(0, 1));
      len = $urandom_range(0, 6);
      rep = ($urandom_range(0, 3) == 0);
      nk  = (!rw && len >= 2 && $urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      if (!rw) for (int i = 0; i < len; i++) push_byte(8'($urandom));
      run_txn(7'($urandom), rw, len, rep, nk, 0, 8'h00);
    end

    // reset while a read is mid-transfer: outputs return to reset values, no done follows
    send_cmd(7'h2B, 1, 3, 0);
    fsm_busy = 1;
    tick();
    tick();
    exp_rd.push_back(8'h5A);
    rx_valid = 1; rx_data = 8'h5A;
    tick();
    idle_inputs();
    rst_n = 0;
    tick();
    check("reset_in_xfer", outv, RST_VEC);
    exp_issue.delete(); exp_done.delete(); exp_tx.delete(); exp_rd.delete();
    mfifo.delete(); rd_src.delete();
    rflag_m = 0;
    tick();
    rst_n = 1;
    repeat (5) tick();

    // fsm_busy never rises
    begin
      done_t dt;
`ifdef I2C_SEQ_TIMEOUT_EN
      dt.status = 2'b10; dt.stop = 1'b1;
      exp_done.push_back(dt);
`endif
      send_cmd(7'h55, 0, 0, 0);
      tick();
      n = 0; seen = 0;
      while (n < 100) begin
        tick();
        n++;
        if (done) begin seen = 1; break; end
      end
`ifdef I2C_SEQ_TIMEOUT_EN
      check("timeout_cycles", n, 16);
      rflag_m = 0;
      repeat (5) tick();
`else
      check("no_done_without_timeout", seen, 0);
      do_reset();
`endif
    end

    push_byte(8'h69);
    run_txn(7'h0F, 0, 1, 0, -1, 0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_txn_seq.md
Name: i2c_txn_seq

Overview:
Host-side transaction sequencer directly upstream of the I2C bit-level FSM (`i2c_fsm`). It accepts one command at a time (7-bit address, R/W, byte count) and buffers write bytes in an internal TX FIFO. It then drives the FSM's start/restart/stop/tx_data/tx_valid controls, consumes tx_ready/busy/error/rx_data/rx_valid, returns read bytes to the host, and reports per-transaction completion status.

Parameters:
FIFO_DEPTH, 8, TX byte FIFO entries; power of two, >=2.
LEN_W, 4, width of byte-count field; max transfer 2**LEN_W-1 bytes.
TIMEOUT_CYCLES, 1023, watchdog limit; used only when I2C_SEQ_TIMEOUT_EN is defined.

Ports:
scl_clk  in  1  single clock; all logic is posedge scl_clk.
rst_n  in  1  synchronous active-low reset, sampled on posedge scl_clk.
cmd_valid  in  1  host command valid.
cmd_ready  out  1  sequencer can accept a command.
cmd_addr  in  7  target address.
cmd_rw  in  1  0 = write, 1 = read.
cmd_len  in  LEN_W  byte count; 0 = address-only probe.
cmd_rep_start  in  1  end without STOP; the next command issues restart.
wr_data  in  8  host write byte into TX FIFO.
wr_valid  in  1  write byte valid.
wr_ready  out  1  FIFO not full.
rd_data  out  8  read byte to host.
rd_valid  out  1  one-cycle pulse per read byte.
done  out  1  one-cycle pulse at transaction end.
status  out  2  valid with done: 00 OK, 01 NACK, 10 timeout, 11 reserved.
seq_busy  out  1  transaction in progress.
cfg_address  out  7  to FSM.
start  out  1  to FSM.
restart  out  1  to FSM.
stop  out  1  to FSM.
tx_data  out  8  to FSM.
tx_valid  out  1  to FSM.
tx_ready  in  1  from FSM.
fsm_busy  in  1  FSM busy output.
fsm_error  in  1  FSM error (sampled ACK bit, 1 = NACK).
rx_data  in  8  from FSM.
rx_valid  in  1  from FSM.

Behaviour:
- Reset: all outputs 0 except wr_ready=1 and cmd_ready=1. FIFO is emptied, byte counter=0, held-restart flag=0, state=IDLE. Reset asserted mid-transaction aborts immediately; no done pulse is produced.
- TX FIFO: push on wr_valid&&wr_ready; pop on tx_valid&&tx_ready. Simultaneous push and pop when full or empty is legal; occupancy is unchanged. Pointers wrap modulo FIFO_DEPTH. Pushing is allowed in any state.
- States: IDLE, ISSUE, WAIT_BUSY, XFER, CLOSE, DRAIN.
- IDLE: cmd_ready=1. On cmd_valid, capture addr/rw/len/rep_start, set cmd_ready=0 the next cycle, go to ISSUE.
- ISSUE: drive cfg_address = captured address. Pulse start for exactly 1 cycle, or restart instead if the held-restart flag=1; then clear the flag. Go to WAIT_BUSY.
- WAIT_BUSY: wait for fsm_busy=1, then go to XFER. cfg_address is held stable for the whole transaction.
- XFER, write: tx_valid = FIFO non-empty && remaining>0; tx_data = FIFO head. Each handshake decrements remaining. An empty FIFO stalls without error.
- XFER, read: each rx_valid emits rd_valid/rd_data in the same cycle (combinational pass-through, zero latency) and decrements remaining.
- XFER, termination: when remaining reaches 0 (or immediately if len=0), go to CLOSE.
- NACK: fsm_error=1 while in XFER or WAIT_BUSY aborts. status=01, stop asserted, go to CLOSE. FIFO entries still owed to this command (remaining count, writes only) are discarded in DRAIN after CLOSE.
- CLOSE: if rep_start=1 and no abort, set the held-restart flag, skip stop, pulse done the next cycle, go to IDLE. Otherwise hold stop=1 until fsm_busy=0, then pulse done, drop stop, and go to DRAIN (abort) or IDLE.
- DRAIN: pop min(remaining, occupancy) per cycle (one per cycle) until remaining=0 or the FIFO is empty, then go to IDLE.
- seq_busy = (state != IDLE).
- A cmd_valid seen while not in IDLE is ignored (not accepted).

Optional Feature:
I2C_SEQ_TIMEOUT_EN:
- Defined: a counter of width clog2(TIMEOUT_CYCLES+1) clears on state change, tx handshake, or rx_valid, and increments otherwise in WAIT_BUSY/XFER/CLOSE. When it reaches TIMEOUT_CYCLES: status=10, assert stop for 1 cycle, pulse done, go to DRAIN. The held-restart flag is cleared.
- Not defined: no counter; status never equals 10; the sequencer can wait indefinitely.

Test Plan:
- Write 3 bytes: push 0xA1, 0x5C, 0x3E; command addr=0x50 rw=0 len=3 -> one start pulse, cfg_address=0x50, three tx handshakes in order, stop held until fsm_busy=0, done with status=00, FIFO empty.
- Read 2 bytes: command addr=0x21 rw=1 len=2; FSM model returns 0x7F, 0x00 -> two rd_valid pulses with the same data in the same cycles, done with status=00, no tx_valid ever asserted.
- NACK mid-write: len=4, four bytes pushed, fsm_error rises after byte 1 -> status=01, stop asserted, remaining 3 bytes drained, FIFO occupancy 0 at IDLE.
- Repeated start: write len=1 with cmd_rep_start=1, then read len=1 -> the first transaction has no stop; the second issues restart (not start); only the final transaction asserts stop.
- Boundaries: fill FIFO to 8 -> wr_ready=0; simultaneous push and pop while full keeps wr_ready=0 and occupancy 8. A len=0 probe -> start then stop, done with status=00. Reset asserted in XFER -> all outputs at reset values the next cycle, no done pulse.
- Timeout (macro defined, TIMEOUT_CYCLES=15): fsm_busy never rises -> done with status=10 exactly 16 cycles after entering WAIT_BUSY; macro undefined -> no done pulse after 100 cycles.
